mb_loader: RTL and testbench

- Sits directly downstream of the raster address generator (`datapath`).
- Consumes its x/y word addresses and converts each to a frame-memory word address.
- Captures the 4-pixel words returned by the memory and assembles them into complete 16x16 macroblocks in a two-entry macroblock buffer.
- Presents each finished macroblock row-addressable to the next encoder stage with a valid/ready handshake, and drives the generator's hold input to start and stop frame scans.

---
 rtl/mb_loader.sv | 165 ++++++++++++++++
 tb/tb_mb_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mb_loader.sv
// Frame-memory word fetch and 16x16 macroblock assembly into a two-entry buffer,
// with row-addressable valid/ready presentation and generator hold control.
module mb_loader #(
  parameter int MACRODIM  = 16,
  parameter int IMGWIDTH  = 48,
  parameter int IMGHEIGHT = 48,
  parameter int PIXW      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [31:0]              x,
  input  logic [31:0]              y,
  input  logic                     stop,
  output logic                     hold,
  output logic [31:0]              mem_addr,
  input  logic [4*PIXW-1:0]        mem_rdata,
  output logic                     mb_valid,
  input  logic                     mb_ready,
  input  logic [3:0]               mb_rd_row,
  output logic [MACRODIM*PIXW-1:0] mb_rd_data,
  output logic [31:0]              mb_x,
  output logic [31:0]              mb_y,
  output logic                     overflow,
  output logic                     frame_done
);

  localparam int WORD_W = 4 * PIXW;
  localparam int ROW_W  = MACRODIM * PIXW;
  localparam int RW     = $clog2(MACRODIM);
  localparam int CW     = $clog2(MACRODIM / 4);

  if ((IMGWIDTH % MACRODIM) != 0 || (IMGHEIGHT % MACRODIM) != 0) begin : g_bad_geometry
    $error("frame dimensions must be multiples of the macroblock edge");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic              vld_p0;
  logic [RW-1:0]     row_p0;
  logic [CW-1:0]     wcol_p0;
  logic [31:0]       x_p0;
  logic [31:0]       y_p0;
  logic [1:0]        busy;
  logic [1:0]        full;
  logic              rd_ptr;
  logic              wr_ptr;
  logic              fill_sel;
  logic              dropping;
  logic [31:0]       base_x [2];
  logic [31:0]       base_y [2];
  logic [ROW_W-1:0]  mb_mem [2][MACRODIM];

  logic [31:0] lin;
  logic        rel;
  logic [1:0]  rel_mask;
  logic        claim;
  logic        last;
  logic        free;
  logic        wr_en;
  logic        wr_sel;
  logic        drain_done;

  always_comb begin
    lin        = y * 32'(IMGWIDTH) + x;
    mem_addr   = lin >> 2;
    mb_valid   = full[rd_ptr];
    mb_rd_data = mb_mem[rd_ptr][mb_rd_row];
    mb_x       = base_x[rd_ptr];
    mb_y       = base_y[rd_ptr];
    rel        = full[rd_ptr] & mb_ready;
    rel_mask   = rel ? (rd_ptr ? 2'b10 : 2'b01) : 2'b00;
    claim      = (row_p0 == '0) && (wcol_p0 == '0);
    last       = (row_p0 == RW'(MACRODIM - 1)) && (wcol_p0 == CW'(MACRODIM / 4 - 1));
    // A buffer being released at this edge can be reclaimed at the same edge.
    free       = !busy[wr_ptr] || (rel && (rd_ptr == wr_ptr));
    wr_en      = vld_p0 && (claim ? free : !dropping);
    wr_sel     = claim ? wr_ptr : fill_sel;
    drain_done = !vld_p0 && ((busy & ~rel_mask) == 2'b00);
  end

  // Control: frame sequencing, buffer ownership, presentation pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      hold       <= 1'b1;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      vld_p0     <= 1'b0;
      busy       <= 2'b00;
      full       <= 2'b00;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fill_sel   <= 1'b0;
      dropping   <= 1'b0;
      base_x     <= '{default: '0};
      base_y     <= '{default: '0};
    end else begin
      vld_p0     <= (state == S_RUN);
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            hold     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        S_RUN: begin
          if (stop) begin
            state <= S_DRAIN;
            hold  <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
            state      <= S_DONE;
            frame_done <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          hold  <= 1'b1;
        end
      endcase

      if (rel) begin
        busy[rd_ptr] <= 1'b0;
        full[rd_ptr] <= 1'b0;
        rd_ptr       <= ~rd_ptr;
      end

      if (vld_p0) begin
        if (claim) begin
          if (free) begin
            busy[wr_ptr] <= 1'b1;
            fill_sel     <= wr_ptr;
            wr_ptr       <= ~wr_ptr;
            dropping     <= 1'b0;
          end else begin
            dropping <= 1'b1;
            overflow <= 1'b1;
          end
        end else if (!dropping && last) begin
          full[fill_sel]   <= 1'b1;
          base_x[fill_sel] <= x_p0 - 32'(MACRODIM - 4);
          base_y[fill_sel] <= y_p0 - 32'(MACRODIM - 1);
        end
      end
    end
  end

  // Stage p0: request coordinates; mem_rdata for them arrives one cycle later
  always_ff @(posedge clk) begin
    row_p0  <= y[RW-1:0];
    wcol_p0 <= x[RW-1:2];
    x_p0    <= x;
    y_p0    <= y;
    if (wr_en) begin
      mb_mem[wr_sel][row_p0][wcol_p0*WORD_W +: WORD_W] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mb_loader.sv
// Directed bench for mb_loader: models the raster generator and a frame memory
// returning {addr+3, addr+2, addr+1, addr} per word.
module tb_mb_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  x, y;
  logic         stop;
  logic         hold;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_rdata = '0;
  logic         mb_valid;
  logic         mb_ready = 1'b0;
  logic [3:0]   mb_rd_row = 4'd0;
  logic [127:0] mb_rd_data;
  logic [31:0]  mb_x, mb_y;
  logic         overflow;
  logic         frame_done;

  int cnt = 0;
  int checks = 0;
  int fails = 0;

  mb_loader #(.MACRODIM(16), .IMGWIDTH(48), .IMGHEIGHT(48), .PIXW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .stop(stop), .hold(hold),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mb_valid(mb_valid), .mb_ready(mb_ready),
    .mb_rd_row(mb_rd_row), .mb_rd_data(mb_rd_data), .mb_x(mb_x), .mb_y(mb_y),
    .overflow(overflow), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Generator: macroblock-ordered scan, cleared while hold is high
  always @(posedge clk) begin
    if (hold) cnt <= 0;
    else      cnt <= cnt + 1;
  end

  always_comb begin
    x    = 32'(((cnt / 64) % 3) * 16 + (cnt % 4) * 4);
    y    = 32'((cnt / 192) * 16 + (cnt % 64) / 4);
    stop = (cnt == 575);
  end

  always @(posedge clk) begin
    mem_rdata <= {mem_addr[7:0] + 8'd3, mem_addr[7:0] + 8'd2, mem_addr[7:0] + 8'd1, mem_addr[7:0]};
  end

  function automatic logic [127:0] exp_row(int mb, int r);
    logic [127:0] v;
    int px, py, a;
    v = '0;
    for (int c = 0; c < 16; c++) begin
      px = (mb % 3) * 16 + c;
      py = (mb / 3) * 16 + r;
      a  = (py * 48 + px) / 4;
      v[c*8 +: 8] = 8'(a + c % 4);
    end
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1500 && !ok; i++) begin
      if (frame_done) ok = 1'b1;
      else tick();
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    checks++; if (hold !== 1'b1) begin fails++; $display("FAIL reset_hold: got %b want 1", hold); end
    checks++; if (mb_valid !== 1'b0) begin fails++; $display("FAIL reset_mb_valid: got %b want 0", mb_valid); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    checks++; if (mb_x !== 32'd0 || mb_y !== 32'd0) begin fails++; $display("FAIL reset_mb_xy: got %0d,%0d want 0,0", mb_x, mb_y); end
    rst = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_frame();
    int n = 0;
    int fd = 0;
    bit seen = 1'b0;
    mb_ready = 1'b1;
    start_frame();
    checks++; if (hold !== 1'b0) begin fails++; $display("FAIL frame_hold_fall: got %b want 0", hold); end
    checks++; if (mem_addr !== 32'd0) begin fails++; $display("FAIL frame_first_addr: got %0d want 0", mem_addr); end
    for (int i = 0; i < 800 && !seen; i++) begin
      if (mb_valid) begin
        checks++;
        if (mb_x !== 32'((n % 3) * 16) || mb_y !== 32'((n / 3) * 16)) begin
          fails++; $display("FAIL frame_mb%0d_xy: got %0d,%0d want %0d,%0d", n, mb_x, mb_y, (n % 3) * 16, (n / 3) * 16);
        end
        mb_rd_row = 4'(n);
        #1;
        checks++; if (mb_rd_data !== exp_row(n, n)) begin fails++; $display("FAIL frame_mb%0d_row%0d: got %h want %h", n, n, mb_rd_data, exp_row(n, n)); end
        if (n == 0) begin
          mb_rd_row = 4'd1;
          #1;
          checks++; if (mb_rd_data[7:0] !== 8'd12) begin fails++; $display("FAIL mb0_row1_col0: got %0d want 12", mb_rd_data[7:0]); end
          checks++; if (mb_rd_data[31:24] !== 8'd15) begin fails++; $display("FAIL mb0_row1_col3: got %0d want 15", mb_rd_data[31:24]); end
          checks++; if (mb_rd_data[127:120] !== 8'd18) begin fails++; $display("FAIL mb0_row1_col15: got %0d want 18", mb_rd_data[127:120]); end
        end
        n++;
      end
      if (frame_done) begin
        fd++;
        seen = 1'b1;
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      if (frame_done) fd++;
      tick();
    end
    checks++; if (n != 9) begin fails++; $display("FAIL frame_mb_count: got %0d want 9", n); end
    checks++; if (fd != 1) begin fails++; $display("FAIL frame_done_pulses: got %0d want 1", fd); end
    checks++; if (hold !== 1'b1) begin fails++; $display("FAIL frame_idle_hold: got %b want 1", hold); end
  endtask

  task automatic test_timing();
    bit found = 1'b0;
    bit ok;
    mb_ready = 1'b1;
    start_frame();
    for (int i = 0; i < 200 && !found; i++) begin
      if (mem_addr == 32'd183 && !hold) found = 1'b1;
      else tick();
    end
    checks++; if (!found) begin fails++; $display("FAIL timing_addr183: got timeout want address seen"); end
    checks++; if (mb_valid !== 1'b0) begin fails++; $display("FAIL timing_t0_valid: got %b want 0", mb_valid); end
    tick();
    checks++; if (mb_valid !== 1'b0) begin fails++; $display("FAIL timing_t1_valid: got %b want 0", mb_valid); end
    tick();
    checks++; if (mb_valid !== 1'b1) begin fails++; $display("FAIL timing_t2_valid: got %b want 1", mb_valid); end
    checks++; if (mb_x !== 32'd0 || mb_y !== 32'd0) begin fails++; $display("FAIL timing_mb_xy: got %0d,%0d want 0,0", mb_x, mb_y); end
    wait_done(ok);
    checks++; if (!ok) begin fails++; $display("FAIL timing_done: got timeout want frame_done"); end
  endtask

  task automatic test_overflow();
    bit found = 1'b0;
    bit ok;
    mb_ready = 1'b0;
    start_frame();
    repeat (200) tick();
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b want 1", overflow); end
    checks++; if (mb_valid !== 1'b1 || mb_x !== 32'd0 || mb_y !== 32'd0) begin fails++; $display("FAIL ovf_first: got v=%b %0d,%0d want v=1 0,0", mb_valid, mb_x, mb_y); end
    mb_rd_row = 4'd2;
    #1;
    checks++; if (mb_rd_data !== exp_row(0, 2)) begin fails++; $display("FAIL ovf_mb0_row2: got %h want %h", mb_rd_data, exp_row(0, 2)); end
    mb_ready = 1'b1;
    tick();
    mb_ready = 1'b0;
    checks++; if (mb_valid !== 1'b1 || mb_x !== 32'd16 || mb_y !== 32'd0) begin fails++; $display("FAIL ovf_second: got v=%b %0d,%0d want v=1 16,0", mb_valid, mb_x, mb_y); end
    mb_ready = 1'b1;
    tick();
    mb_ready = 1'b0;
    checks++; if (mb_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty: got %b want 0", mb_valid); end
    for (int i = 0; i < 200 && !found; i++) begin
      if (mb_valid) found = 1'b1;
      else tick();
    end
    checks++; if (!found || mb_x !== 32'd16 || mb_y !== 32'd16) begin fails++; $display("FAIL ovf_third: got v=%b %0d,%0d want v=1 16,16", mb_valid, mb_x, mb_y); end
    mb_rd_row = 4'd7;
    #1;
    checks++; if (mb_rd_data !== exp_row(4, 7)) begin fails++; $display("FAIL ovf_mb4_row7: got %h want %h", mb_rd_data, exp_row(4, 7)); end
    mb_ready = 1'b1;
    wait_done(ok);
    checks++; if (!ok) begin fails++; $display("FAIL ovf_done: got timeout want frame_done"); end
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_midreset();
    bit found = 1'b0;
    bit seen = 1'b0;
    int n = 0;
    mb_ready = 1'b0;
    start_frame();
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL mid_ovf_clear_on_start: got %b want 0", overflow); end
    for (int i = 0; i < 200 && !found; i++) begin
      if (x == 32'd20 && y == 32'd5 && !hold) found = 1'b1;
      else tick();
    end
    checks++; if (!found || mb_valid !== 1'b1) begin fails++; $display("FAIL mid_pending: got found=%b v=%b want 1,1", found, mb_valid); end
    rst = 1'b0;
    #1;
    checks++; if (mb_valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b want 0", mb_valid); end
    checks++; if (hold !== 1'b1) begin fails++; $display("FAIL mid_hold: got %b want 1", hold); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL mid_overflow: got %b want 0", overflow); end
    tick();
    rst = 1'b1;
    tick();
    mb_ready = 1'b1;
    start_frame();
    checks++; if (hold !== 1'b0 || mem_addr !== 32'd0) begin fails++; $display("FAIL mid_rescan: got hold=%b addr=%0d want 0,0", hold, mem_addr); end
    for (int i = 0; i < 800 && !seen; i++) begin
      if (mb_valid) begin
        if (n == 0) begin
          checks++; if (mb_x !== 32'd0 || mb_y !== 32'd0) begin fails++; $display("FAIL mid_first_mb: got %0d,%0d want 0,0", mb_x, mb_y); end
        end
        n++;
      end
      if (frame_done) seen = 1'b1;
      tick();
    end
    checks++; if (!seen || n != 9) begin fails++; $display("FAIL mid_frame_count: got done=%b n=%0d want 1,9", seen, n); end
  endtask

  task automatic test_start_ignored();
    bit seen = 1'b0;
    bit prev_stop = 1'b0;
    int n = 0;
    mb_ready = 1'b1;
    start_frame();
    for (int i = 0; i < 1000 && !seen; i++) begin
      if (mb_valid) n++;
      if (frame_done) begin
        seen  = 1'b1;
        start = 1'b0;
      end else begin
        start = ((i % 50) == 25) || stop || prev_stop;
      end
      prev_stop = stop;
      tick();
    end
    start = 1'b0;
    checks++; if (!seen || n != 9) begin fails++; $display("FAIL ign_count: got done=%b n=%0d want 1,9", seen, n); end
    repeat (3) tick();
    checks++; if (hold !== 1'b1 || frame_done !== 1'b0) begin fails++; $display("FAIL ign_idle: got hold=%b fd=%b want 1,0", hold, frame_done); end
  endtask

  task automatic test_drain_wait();
    bit found = 1'b0;
    int bad = 0;
    mb_ready = 1'b0;
    start_frame();
    for (int i = 0; i < 800 && !found; i++) begin
      if (stop && !hold) found = 1'b1;
      else tick();
    end
    checks++; if (!found) begin fails++; $display("FAIL drain_stop: got timeout want stop"); end
    tick();
    for (int i = 0; i < 100; i++) begin
      if (frame_done !== 1'b0 || hold !== 1'b1) bad++;
      tick();
    end
    checks++; if (bad != 0) begin fails++; $display("FAIL drain_wait: got %0d bad cycles want 0", bad); end
    checks++; if (mb_valid !== 1'b1 || mb_x !== 32'd0 || overflow !== 1'b1) begin fails++; $display("FAIL drain_pending: got v=%b x=%0d ovf=%b want 1,0,1", mb_valid, mb_x, overflow); end
    mb_ready = 1'b1;
    tick();
    mb_ready = 1'b0;
    checks++; if (frame_done !== 1'b0 || mb_valid !== 1'b1 || mb_x !== 32'd16) begin fails++; $display("FAIL drain_after1: got fd=%b v=%b x=%0d want 0,1,16", frame_done, mb_valid, mb_x); end
    mb_ready = 1'b1;
    tick();
    mb_ready = 1'b0;
    checks++; if (frame_done !== 1'b1 || mb_valid !== 1'b0) begin fails++; $display("FAIL drain_done_pulse: got fd=%b v=%b want 1,0", frame_done, mb_valid); end
    tick();
    checks++; if (frame_done !== 1'b0 || hold !== 1'b1) begin fails++; $display("FAIL drain_done_end: got fd=%b hold=%b want 0,1", frame_done, hold); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_frame();
    test_timing();
    test_overflow();
    test_midreset();
    test_start_ignored();
    test_drain_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
